// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between a byte source and the UART transmitter.
//   tx_data  : byte to send, sampled only in the accept cycle
//   tx_valid : tx_data is valid; the source holds it until it sees tx_ready
//   tx_ready : transmitter can accept a byte (transmitter is idle)
// Modports:
//   master : byte source side (drives tx_data/tx_valid)
//   slave  : transmitter side (drives tx_ready)
// -----------------------------------------------------------------------------
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Shifts a parallel byte out LSB first as a
// start / data / [parity] / stop frame, one bit per baud_tick strobe.
//
// Optional feature macro: PARITY_EN
//   defined     : a parity bit follows the data bits (even, or odd when
//                 PARITY_ODD=1)
//   not defined : no parity state or logic; PARITY_ODD is ignored
//
// Ports:
//   clk       in   system clock, all registers update on its rising edge
//   rst       in   synchronous reset, active-high
//   baud_tick in   one-clk strobe per bit period from the baud divider
//   s_bus     if   byte handshake (tx_data, tx_valid in; tx_ready out)
//   tx        out  serial line, registered, idles high
//   tx_busy   out  high from the accept cycle until the frame ends
//   tx_done   out  one-clk pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      baud_tick,
   uart_tx_if.slave  s_bus,
   output logic      tx,
   output logic      tx_busy,
   output logic      tx_done
);

   // bit_cnt reaches at most DATA_BITS, stop_cnt at most STOP_BITS
   localparam int CW = $clog2(DATA_BITS + 1);
   localparam int SW = $clog2(STOP_BITS + 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   // Parity over the latched data bits, inverted for odd parity
   function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_STOP   = 3'd5
   } state_t;

   // PARITY_ODD has no meaning without the parity feature
   logic w_unused_par;
   assign w_unused_par = (PARITY_ODD != 0);
`endif

   state_t               r_state,    w_state_nxt;
   logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
   logic [CW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
   logic [SW-1:0]        r_stop_cnt, w_stop_cnt_nxt;
   logic                 r_tx,       w_tx_nxt;
   logic                 r_busy,     w_busy_nxt;
   logic                 r_done,     w_done_nxt;
`ifdef PARITY_EN
   logic                 r_parity,   w_parity_nxt;
`endif

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
`ifdef PARITY_EN
         r_parity   <= w_parity_nxt;
`endif
      end
   end

   // Next-state, datapath and line-level decode; tx follows the current
   // state so the line changes one clock after the tick edge
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_tx_nxt       = 1'b1;
`ifdef PARITY_EN
      w_parity_nxt   = r_parity;
`endif
      case (r_state)
         S_IDLE: begin
            // baud_tick is ignored here so the start bit always gets a
            // full period after ALIGN
            w_tx_nxt = 1'b1;
            if (s_bus.tx_valid) begin
               w_state_nxt    = S_ALIGN;
               w_shift_nxt    = s_bus.tx_data;
               w_bit_cnt_nxt  = '0;
               w_stop_cnt_nxt = '0;
               w_busy_nxt     = 1'b1;
`ifdef PARITY_EN
               w_parity_nxt   = f_parity(s_bus.tx_data);
`endif
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ALIGN: begin
            w_tx_nxt = 1'b1;
            if (baud_tick) begin
               w_state_nxt = S_START;
            end else begin
               w_state_nxt = S_ALIGN;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (baud_tick) begin
               w_state_nxt   = S_DATA;
               w_bit_cnt_nxt = '0;
            end else begin
               w_state_nxt = S_START;
            end
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (baud_tick) begin
               w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
               if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
                  w_state_nxt    = S_PARITY;
`else
                  w_state_nxt    = S_STOP;
`endif
                  w_bit_cnt_nxt  = '0;
                  w_stop_cnt_nxt = '0;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + CW'(1);
               end
            end else begin
               w_state_nxt = S_DATA;
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            w_tx_nxt = r_parity;
            if (baud_tick) begin
               w_state_nxt    = S_STOP;
               w_stop_cnt_nxt = '0;
            end else begin
               w_state_nxt = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (baud_tick) begin
               if (r_stop_cnt == SW'(STOP_BITS - 1)) begin
                  w_state_nxt    = S_IDLE;
                  w_stop_cnt_nxt = '0;
                  w_busy_nxt     = 1'b0;
                  w_done_nxt     = 1'b1;
               end else begin
                  w_stop_cnt_nxt = r_stop_cnt + SW'(1);
               end
            end else begin
               w_state_nxt = S_STOP;
            end
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_bit_cnt_nxt  = '0;
            w_stop_cnt_nxt = '0;
            w_busy_nxt     = 1'b0;
            w_tx_nxt       = 1'b1;
         end
      endcase
   end

   assign s_bus.tx_ready = (r_state == S_IDLE);
   assign tx             = r_tx;
   assign tx_busy        = r_busy;
   assign tx_done        = r_done;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx. baud_tick strobes every 10 clks. dut0 uses
// default parameters, dut1 uses STOP_BITS=2; with PARITY_EN defined a third
// instance uses PARITY_ODD=1. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef PARITY_EN
   localparam int HP = 1;
`else
   localparam int HP = 0;
`endif

   logic clk;
   logic rst;
   logic baud_tick;
   int   tick_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cur_sel  = 0;

   uart_tx_if #(.DATA_BITS(8)) if0 ();
   uart_tx_if #(.DATA_BITS(8)) if1 ();
   logic tx0, busy0, done0;
   logic tx1, busy1, done1;

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_bus(if0),
      .tx(tx0), .tx_busy(busy0), .tx_done(done0)
   );

   uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_bus(if1),
      .tx(tx1), .tx_busy(busy1), .tx_done(done1)
   );

`ifdef PARITY_EN
   uart_tx_if #(.DATA_BITS(8)) if2 ();
   logic tx2, busy2, done2;
   uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .s_bus(if2),
      .tx(tx2), .tx_busy(busy2), .tx_done(done2)
   );
`endif

   // Outputs of the instance currently under test
   logic tx_s, rdy_s, busy_s, done_s;
   always_comb begin
      tx_s = tx0; rdy_s = if0.tx_ready; busy_s = busy0; done_s = done0;
      case (cur_sel)
         1: begin tx_s = tx1; rdy_s = if1.tx_ready; busy_s = busy1; done_s = done1; end
`ifdef PARITY_EN
         2: begin tx_s = tx2; rdy_s = if2.tx_ready; busy_s = busy2; done_s = done2; end
`endif
         default: begin end
      endcase
   end

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-clk baud strobe every 10 clks, changed on the falling edge
   initial begin
      tick_cnt  = 0;
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_cnt  = (tick_cnt == 9) ? 0 : tick_cnt + 1;
         baud_tick = (tick_cnt == 9);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      case (sel)
         1: begin if1.tx_valid = v; if1.tx_data = d; end
`ifdef PARITY_EN
         2: begin if2.tx_valid = v; if2.tx_data = d; end
`endif
         default: begin if0.tx_valid = v; if0.tx_data = d; end
      endcase
   endtask

   // Expected frame, bit 0 first: start, data LSB first, [parity], stop ones
   function automatic logic [11:0] mk(input logic [7:0] d, input logic par);
      logic [11:0] f;
      f      = 12'hFFF;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (HP == 1) f[9] = par;
      return f;
   endfunction

   // Present a byte while idle; it must be taken on the next edge
   task automatic accept(input int sel, input logic [7:0] d);
      cur_sel = sel;
      drive(sel, 1'b1, d);
      @(negedge clk);
      check_eq("accept_busy", 32'(busy_s), 32'd1);
      check_eq("accept_ready_low", 32'(rdy_s), 32'd0);
      drive(sel, 1'b0, d);
   endtask

   // Find the start bit, then require every bit to hold exactly 10 clks,
   // tx_ready low until tx_done, and a single tx_done on the last sample
   task automatic check_frame(input int sel, input string name, input logic [11:0] bits,
                              input int nb, input logic b2b);
      int w = 0;
      int ok;
      int done_cnt = 0;
      int done_idx = -1;
      int rdy_bad  = 0;
      logic rdy_at_done = 1'b0;
      cur_sel = sel;
      while (tx_s !== 1'b0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_eq({name, "_start_seen"}, 32'(tx_s === 1'b0), 32'd1);
      for (int b = 0; b < nb; b++) begin
         ok = 0;
         for (int k = 0; k < 10; k++) begin
            if (tx_s === bits[b]) ok++;
            if (done_s === 1'b1) begin
               done_cnt++;
               done_idx    = b * 10 + k;
               rdy_at_done = rdy_s;
            end
            if (!(b == nb - 1 && k == 9) && rdy_s !== 1'b0) rdy_bad++;
            @(negedge clk);
         end
         check_eq($sformatf("%s_bit%0d_clks", name, b), 32'(ok), 32'd10);
      end
      check_eq({name, "_done_count"}, 32'(done_cnt), 32'd1);
      check_eq({name, "_done_at_end"}, 32'(done_idx), 32'(nb * 10 - 1));
      check_eq({name, "_ready_low_in_frame"}, 32'(rdy_bad), 32'd0);
      check_eq({name, "_ready_at_done"}, 32'(rdy_at_done), 32'd1);
      check_eq({name, "_busy_after"}, 32'(busy_s), 32'(b2b));
      check_eq({name, "_ready_after"}, 32'(rdy_s), 32'(!b2b));
   endtask

   initial begin
      int ones, rdy, bsy, dn;
      rst = 1'b1;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
`ifdef PARITY_EN
      drive(2, 1'b0, 8'h00);
`endif
      // 1. reset state, then ticks with no traffic change nothing
      repeat (2) @(negedge clk);
      cur_sel = 0;
      check_eq("rst_tx", 32'(tx_s), 32'd1);
      check_eq("rst_ready", 32'(rdy_s), 32'd1);
      check_eq("rst_busy", 32'(busy_s), 32'd0);
      check_eq("rst_done", 32'(done_s), 32'd0);
      rst = 1'b0;
      ones = 0; rdy = 0; bsy = 0; dn = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         ones += int'(tx_s === 1'b1);
         rdy  += int'(rdy_s === 1'b1);
         bsy  += int'(busy_s === 1'b1);
         dn   += int'(done_s === 1'b1);
      end
      check_eq("idle_tx_high", 32'(ones), 32'd30);
      check_eq("idle_ready", 32'(rdy), 32'd30);
      check_eq("idle_busy", 32'(bsy), 32'd0);
      check_eq("idle_done", 32'(dn), 32'd0);

      // 2. 0x55: 0,1,0,1,0,1,0,1,0,1 (even parity bit 0 when enabled)
      accept(0, 8'h55);
      check_frame(0, "f55", mk(8'h55, 1'b0), 10 + HP, 1'b0);

      // 3. 0xA3 then 0x0F with tx_valid held; 0x0F taken right after tx_done
      accept(0, 8'hA3);
      drive(0, 1'b1, 8'h0F);
      check_frame(0, "fA3", mk(8'hA3, 1'b0), 10 + HP, 1'b1);
      drive(0, 1'b0, 8'h0F);
      check_frame(0, "f0F", mk(8'h0F, 1'b0), 10 + HP, 1'b0);

`ifdef PARITY_EN
      // 4. 0xA3 has four ones: even parity 0, odd parity 1
      accept(0, 8'hA3);
      check_frame(0, "parE", mk(8'hA3, 1'b0), 11, 1'b0);
      accept(2, 8'hA3);
      check_frame(2, "parO", mk(8'hA3, 1'b1), 11, 1'b0);
`endif

      // 5. two stop bits: line high 20 clks, tx_done at end of second stop
      accept(1, 8'hFF);
      check_frame(1, "stop2", mk(8'hFF, 1'b0), 11 + HP, 1'b0);

      // 6. reset in the middle of data bit 3 of 0x00
      accept(0, 8'h00);
      cur_sel = 0;
      begin
         int w = 0;
         while (tx_s !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
         end
      end
      check_eq("abort_start_seen", 32'(tx_s === 1'b0), 32'd1);
      repeat (45) @(negedge clk);
      check_eq("abort_mid_bit3_low", 32'(tx_s), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_tx", 32'(tx_s), 32'd1);
      check_eq("abort_busy", 32'(busy_s), 32'd0);
      check_eq("abort_ready", 32'(rdy_s), 32'd1);
      check_eq("abort_done", 32'(done_s), 32'd0);
      ones = 0; dn = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         ones += int'(tx_s === 1'b1);
         dn   += int'(done_s === 1'b1);
      end
      check_eq("abort_line_high", 32'(ones), 32'd30);
      check_eq("abort_no_done", 32'(dn), 32'd0);
      accept(0, 8'h81);
      check_frame(0, "f81", mk(8'h81, 1'b0), 10 + HP, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_tx
